// File: rtl/bk_multiword_add_seq.sv
// Multi-word add/subtract sequencer around an external combinational adder.
// One WIDTH-bit word per beat, LSW first, with a single output register.
`ifndef ADDER_SIZE
`define ADDER_SIZE 8
`endif

module bk_multiword_add_seq #(
  parameter int WIDTH     = `ADDER_SIZE,
  parameter int MAX_WORDS = 8,
  parameter int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_last,
  input  logic             in_sub,
  output logic [WIDTH-1:0] add_op1,
  output logic [WIDTH-1:0] add_op2,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_res,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic {FIRST, MID} state_t;

  state_t           state;
  logic             carry_q;
  logic             sub_q;
  logic [IDX_W-1:0] idx_q;

  logic accept;
  logic mode;
  logic at_max;
  logic eff_last;
  logic ovf;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // The first word of a frame takes its mode and carry-in straight from the port
  assign mode    = (state == FIRST) ? in_sub : sub_q;
  assign add_op1 = in_op1;
  assign add_op2 = in_op2 ^ {WIDTH{mode}};
  assign add_cin = (state == FIRST) ? in_sub : carry_q;

  assign at_max   = (idx_q == IDX_W'(MAX_WORDS - 1));
  assign eff_last = in_last | at_max;

  assign ovf = (in_op1[WIDTH-1] == add_op2[WIDTH-1]) &
               (add_res[WIDTH-1] != in_op1[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FIRST;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_res   <= add_res;
      out_idx   <= idx_q;
      out_last  <= eff_last;
      if (state == FIRST) sub_q <= in_sub;
      if (eff_last) begin
        state    <= FIRST;
        carry_q  <= 1'b0;
        idx_q    <= '0;
        out_cout <= add_cout;
        out_ovf  <= ovf;
        out_err  <= ~in_last;
      end else begin
        state    <= MID;
        carry_q  <= add_cout;
        idx_q    <= idx_q + 1'b1;
        out_cout <= 1'b0;
        out_ovf  <= 1'b0;
        out_err  <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Bench for bk_multiword_add_seq: frame-level arithmetic model checked each
// cycle, plus literal results for hand-worked frames.
module tb_bk_multiword_add_seq;

  localparam int W  = 8;
  localparam int MW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_op1 = '0;
  logic [W-1:0]  in_op2 = '0;
  logic          in_last = 1'b0;
  logic          in_sub = 1'b0;
  logic [W-1:0]  add_op1;
  logic [W-1:0]  add_op2;
  logic          add_cin;
  logic [W-1:0]  add_res;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_res;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_cout;
  logic          out_ovf;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_res} = {1'b0, add_op1} + {1'b0, add_op2} + (W+1)'(add_cin);

  bk_multiword_add_seq #(.WIDTH(W), .MAX_WORDS(MW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_last(in_last), .in_sub(in_sub),
    .add_op1(add_op1), .add_op2(add_op2), .add_cin(add_cin),
    .add_res(add_res), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_idx(out_idx), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err)
  );

  // Model state: what the output register must hold, and the open frame
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_res = '0;
  logic [IW-1:0] m_idx = '0;
  logic          m_last = 1'b0;
  logic          m_cout = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_err = 1'b0;
  logic          m_ready;
  bit            in_frame = 1'b0;
  bit            f_sub = 1'b0;
  int            widx = 0;
  longint unsigned fa = 0;
  longint unsigned fb = 0;
  longint unsigned full;
  longint        sa, sb, sr, lim;
  int            nb;
  bit            lst;

  logic [13:0] mon_q[$];
  logic [13:0] got_v, want_v;

  always @(negedge clk) begin
    m_ready = ~m_valid | out_ready;
    got_v  = {out_res, out_idx, out_last, out_cout, out_ovf, out_err};
    want_v = {m_res, m_idx, m_last, m_cout, m_ovf, m_err};
    checks++;
    if (in_ready !== m_ready || out_valid !== m_valid || got_v !== want_v) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got rdy=%b vld=%b f=%h want rdy=%b vld=%b f=%h",
               $time, in_ready, out_valid, got_v, m_ready, m_valid, want_v);
    end
    if (out_valid && out_ready) mon_q.push_back(got_v);
    if (rst) begin
      m_valid = 0; m_res = 0; m_idx = 0; m_last = 0;
      m_cout = 0; m_ovf = 0; m_err = 0; in_frame = 0;
    end else if (in_valid && m_ready) begin
      if (!in_frame) begin
        widx = 0; f_sub = in_sub; fa = 0; fb = 0;
      end
      fa = fa | (longint'(in_op1) << (8 * widx));
      fb = fb | (longint'(in_op2) << (8 * widx));
      nb = 8 * (widx + 1);
      lst = in_last || (widx == MW - 1);
      full = f_sub ? fa - fb : fa + fb;
      m_res = W'(full >> (8 * widx));
      m_idx = IW'(widx);
      m_last = lst;
      m_valid = 1;
      if (lst) begin
        m_cout = f_sub ? (fa >= fb) : full[nb];
        sa = $signed(fa << (64 - nb)) >>> (64 - nb);
        sb = $signed(fb << (64 - nb)) >>> (64 - nb);
        sr = f_sub ? sa - sb : sa + sb;
        lim = 64'sd1 <<< (nb - 1);
        m_ovf = (sr >= lim) || (sr < -lim);
        m_err = !in_last;
        in_frame = 0;
      end else begin
        m_cout = 0; m_ovf = 0; m_err = 0;
        in_frame = 1;
        widx++;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic l, input logic s, input int want_cin);
    in_op1 = a; in_op2 = b; in_last = l; in_sub = s; in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (want_cin >= 0 && k == 0) begin
        checks++;
        if (add_cin !== want_cin[0]) begin
          errors++;
          $display("FAIL first_word_cin got %b want %0d", add_cin, want_cin);
        end
      end
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    errors++;
    $display("FAIL accept_timeout got in_ready=0 want accept within 60 cycles");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int i, input logic [13:0] want);
    checks++;
    if (i >= mon_q.size()) begin
      errors++;
      $display("FAIL %s got no transfer #%0d want %h", name, i, want);
    end else if (mon_q[i] !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, mon_q[i], want);
    end
  endtask

  bit rnd_done;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_res, out_idx, out_last, out_cout, out_ovf, out_err} !== '0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got vld=%b res=%h rdy=%b want 0/00/1",
               out_valid, out_res, in_ready);
    end
    @(posedge clk); #1;

    // 0x00FF + 0x0001
    mon_q.delete();
    send(8'hFF, 8'h01, 0, 0, 0);
    send(8'h00, 8'h00, 1, 0, -1);
    drain();
    chk("add2_w0", 0, {8'h00, 2'd0, 4'b0000});
    chk("add2_w1", 1, {8'h01, 2'd1, 4'b1000});

    // 0x0100 - 0x0001, in_sub dropped on word 1
    mon_q.delete();
    send(8'h00, 8'h01, 0, 1, 1);
    send(8'h01, 8'h00, 1, 0, -1);
    drain();
    chk("sub2_w0", 0, {8'hFF, 2'd0, 4'b0000});
    chk("sub2_w1", 1, {8'h00, 2'd1, 4'b1100});

    // single-word overflow and carry
    mon_q.delete();
    send(8'h7F, 8'h01, 1, 0, 0);
    send(8'hFF, 8'h01, 1, 0, 0);
    drain();
    chk("ovf_7f", 0, {8'h80, 2'd0, 4'b1010});
    chk("cout_ff", 1, {8'h00, 2'd0, 4'b1100});

    // backpressure mid-frame, then back-to-back single-word frames
    mon_q.delete();
    out_ready = 1'b0;
    send(8'hFF, 8'h01, 0, 0, 0);
    fork
      send(8'h01, 8'h01, 0, 0, -1);
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
    join
    send(8'h02, 8'h00, 1, 0, -1);
    send(8'h11, 8'h22, 1, 0, 0);
    send(8'h44, 8'h55, 1, 0, 0);
    drain();
    chk("bp_w0", 0, {8'h00, 2'd0, 4'b0000});
    chk("bp_w1", 1, {8'h03, 2'd1, 4'b0000});
    chk("bp_w2", 2, {8'h02, 2'd2, 4'b1000});
    chk("b2b_a", 3, {8'h33, 2'd0, 4'b1000});
    chk("b2b_b", 4, {8'h99, 2'd0, 4'b1010});

    // truncation at MAX_WORDS
    mon_q.delete();
    for (int i = 0; i < 4; i++) send(8'h80, 8'h80, 0, 0, (i == 0) ? 0 : -1);
    send(8'h05, 8'h03, 0, 1, 1);
    send(8'h00, 8'h00, 1, 0, -1);
    drain();
    chk("trunc_w1", 1, {8'h01, 2'd1, 4'b0000});
    chk("trunc_w3", 3, {8'h01, 2'd3, 4'b1111});
    chk("trunc_new0", 4, {8'h02, 2'd0, 4'b0000});
    chk("trunc_new1", 5, {8'h00, 2'd1, 4'b1100});

    // reset in the middle of a frame
    mon_q.delete();
    send(8'hFF, 8'h01, 0, 0, 0);
    send(8'hFF, 8'h00, 0, 0, -1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_res !== 8'h00) begin
      errors++;
      $display("FAIL midframe_reset got vld=%b res=%h want 0/00", out_valid, out_res);
    end
    mon_q.delete();
    @(posedge clk); #1;
    send(8'h10, 8'h01, 1, 1, 1);
    drain();
    chk("post_reset", 0, {8'h0F, 2'd0, 4'b1100});

    // randomized frames with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int f = 0; f < 150; f++) begin
          int len;
          bit s;
          len = $urandom_range(1, 5);
          s = $urandom_range(0, 1);
          for (int w = 0; w < len; w++) begin
            send(8'($urandom), 8'($urandom), (w == len - 1), s, -1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_multiword_add_seq.md
# bk_multiword_add_seq

Sequencer that adds or subtracts long operands, one `WIDTH`-bit word per beat, LSW first, by driving the team's combinational Brent-Kung adder.
- Upstream side: accepts a valid/ready word stream.
- Toward the adder: presents the current word and the chained carry, and registers the adder's sum and carry-out.
- Downstream side: emits result words on a valid/ready stream.
- Effective operand length is `MAX_WORDS * WIDTH` bits.

## Interface
- `WIDTH`, default `` `ADDER_SIZE ``: word width; must equal the connected adder width (power of 2).
- `MAX_WORDS`, default 8: maximum words per frame (≥2).
- `IDX_W`, default `$clog2(MAX_WORDS)`: word-index width.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an input word is present.
- `in_ready` out 1: the block can accept a word this cycle.
- `in_op1` in `WIDTH`: operand A word.
- `in_op2` in `WIDTH`: operand B word.
- `in_last` in 1: this is the final (most significant) word of the frame.
- `in_sub` in 1: 1 = A−B, 0 = A+B; sampled on the first word of a frame only.
- `add_op1` out `WIDTH`: drives the adder `in_op1`.
- `add_op2` out `WIDTH`: drives the adder `in_op2`.
- `add_cin` out 1: drives the adder `cin`.
- `add_res` in `WIDTH`: from the adder `out_res`.
- `add_cout` in 1: from the adder `cout`.
- `out_valid` out 1: result word is valid.
- `out_ready` in 1: downstream accepts the result word.
- `out_res` out `WIDTH`: result word.
- `out_idx` out `IDX_W`: word index within the frame (0 = LSW).
- `out_last` out 1: final word of the frame.
- `out_cout` out 1: carry-out of the final word; 0 when `out_last`=0.
- `out_ovf` out 1: signed overflow of the full-length result; 0 when `out_last`=0.
- `out_err` out 1: frame was truncated at `MAX_WORDS`; 0 when `out_last`=0.

## Operation
- Handshake:
  - `accept = in_valid & in_ready`.
  - `in_ready = ~out_valid | out_ready` (single output register, full-throughput pass-through).
- Frame FSM, two states:
  - FIRST: next accepted word starts a frame.
  - MID: inside a frame.
  - FIRST→MID on accept with effective last = 0.
  - Any accept with effective last = 1 returns to FIRST.
- Mode:
  - In FIRST, the accepted `in_sub` is captured into `sub_q`.
  - In MID, `in_sub` is ignored and `sub_q` is used.
- Adder drive (combinational, valid every cycle):
  - `add_op1 = in_op1`.
  - `add_op2 = in_op2 ^ {WIDTH{mode}}`, where mode = `in_sub` in FIRST and `sub_q` in MID.
  - `add_cin`:
    - in FIRST: `in_sub`;
    - in MID: `carry_q`.
- Carry register:
  - On accept: `carry_q <= add_cout`.
  - On the last word: `carry_q <= 0`.
- Index counter `idx_q`:
  - Increments on every non-last accept.
  - Clears to 0 on a last accept.
- Effective last = `in_last | (idx_q == MAX_WORDS-1)`.
  - Forced truncation (`in_last`=0 at index `MAX_WORDS-1`) closes the frame with `out_err`=1.
  - The next word begins a new frame.
- Output register, loaded on accept:
  - `out_res <= add_res`, `out_idx <= idx_q`, `out_last <=` effective last.
  - On the last word only: `out_cout <= add_cout`, `out_err` as defined above, and
    `out_ovf <= (in_op1[MSB] == add_op2[MSB]) & (add_res[MSB] != in_op1[MSB])`.
  - On non-last words these three flags are 0.
- Valid and stall:
  - `out_valid` sets on accept and clears on `out_ready` without a simultaneous accept.
  - Accept and output transfer in the same cycle keeps `out_valid`=1 and loads the new word.
  - While `out_valid & ~out_ready`, all output fields hold stable.
- Single-word frame (`in_last`=1 in FIRST): behaves as one `WIDTH`-bit add or subtract.

## Timing
- Latency: 1 cycle from accept to `out_valid` for the same word.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Critical path: `in_op*` → adder → `out_res`/`carry_q`. The adder is combinational and there is no internal pipeline.
- Reset values:
  - `out_valid`, `out_res`, `out_idx`, `out_last`, `out_cout`, `out_ovf`, `out_err` = 0.
  - `carry_q`, `sub_q`, `idx_q` = 0; FSM = FIRST.
  - `in_ready` = 1 in the cycle after reset.
- Reset mid-frame aborts the frame. The partial carry is discarded, and the next accepted word is treated as a first word.
- `rst` has priority over accept in the same cycle.

## Test plan
- WIDTH=8, 2-word add: (0x00FF, 0x0001) → words 0x00 (idx0), then 0x01 (idx1, last); `out_cout`=0, `out_ovf`=0.
- 2-word subtract 0x0100−0x0001 → 0xFF, 0x00; `out_cout`=1 (no borrow), `out_ovf`=0. `in_sub` toggled on word 1 has no effect.
- Signed overflow, 1-word add 0x7F+0x01 → 0x80, `out_ovf`=1, `out_cout`=0. Then 0xFF+0x01 → 0x00, `out_cout`=1, `out_ovf`=0.
- Backpressure:
  - Drive `out_ready`=0 for 3 cycles mid-frame: `in_ready`=0 and output fields stay stable.
  - Release: words continue in order and the carry is preserved.
  - Back-to-back frames with `out_ready`=1 show no bubble.
- Truncation, MAX_WORDS=4: drive 5 words with `in_last`=0. Word idx3 gets `out_last`=1, `out_err`=1; the 5th word emerges as idx0 of a new frame with `add_cin` = its `in_sub`.
- Reset asserted after word 1 of a 3-word frame: the output clears. The next word is idx0 with cin = `in_sub`, and no stale carry appears.
